// File: rtl/adder_tree_accum_pkg.sv
// Shared constants, FSM state type and helpers for the adder-tree accumulator.
package adder_tree_pkg;

    localparam int ADDER_WIDTH = 13;
    localparam int SUM_WIDTH   = ADDER_WIDTH + 3;
    localparam int MAX_LOG     = 8;
    localparam int ACC_WIDTH   = SUM_WIDTH + MAX_LOG;
    localparam int CNT_WIDTH   = MAX_LOG + 1;
    localparam int LOG_WIDTH   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } accum_state_t;

    // Limit a requested block log2 to the largest supported value.
    function automatic logic [LOG_WIDTH-1:0] clamp_log(input logic [LOG_WIDTH-1:0] req);
        return (req > LOG_WIDTH'(MAX_LOG)) ? LOG_WIDTH'(MAX_LOG) : req;
    endfunction

endpackage

// File: rtl/adder_tree_accum_if.sv
// Tree-result input stream and block-result output stream of the accumulator.
interface adder_tree_accum_if;
    import adder_tree_pkg::*;

    logic                 in_valid;
    logic [SUM_WIDTH-1:0] in_sum;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic [SUM_WIDTH-1:0] out_mean;

    modport master (
        output in_valid, in_sum, out_ready,
        input  out_valid, out_acc, out_mean
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output out_valid, out_acc, out_mean
    );

endinterface

// File: rtl/adder_tree_accum_outreg.sv
// Single-entry block-result holding register with valid/ready and sticky overrun.
module adder_tree_accum_outreg
    import adder_tree_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpl_i,
    input  logic [ACC_WIDTH-1:0] cpl_acc_i,
    input  logic [LOG_WIDTH-1:0] cpl_log_i,
    input  logic                 out_ready_i,
    input  logic                 clr_overrun_i,
    output logic                 out_valid_o,
    output logic [ACC_WIDTH-1:0] out_acc_o,
    output logic [SUM_WIDTH-1:0] out_mean_o,
    output logic                 overrun_o
);

    logic                 valid_q, valid_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [SUM_WIDTH-1:0] mean_q, mean_d;
    logic                 overrun_q, overrun_d;
    logic                 slot_free;
    logic                 drop;

    // Load on a completion when the slot is free, drop and flag otherwise.
    always_comb begin
        valid_d   = valid_q;
        acc_d     = acc_q;
        mean_d    = mean_q;
        slot_free = !valid_q || out_ready_i;
        drop      = cpl_i && !slot_free;

        if (cpl_i && slot_free) begin
            valid_d = 1'b1;
            acc_d   = cpl_acc_i;
            // sum < 2^(SUM_WIDTH+log), so the shifted value fits SUM_WIDTH
            mean_d  = SUM_WIDTH'(cpl_acc_i >> cpl_log_i);
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end

        // A new drop takes priority over a clear in the same cycle.
        overrun_d = (overrun_q && !clr_overrun_i) || drop;
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            acc_q     <= '0;
            mean_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            acc_q     <= acc_d;
            mean_q    <= mean_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_acc_o   = acc_q;
    assign out_mean_o  = mean_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/adder_tree_accum.sv
// Accumulates 2^blk_log consecutive adder-tree results into a block total and mean.
module adder_tree_accum
    import adder_tree_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    adder_tree_accum_if.slave      bus,
    input  logic [LOG_WIDTH-1:0]   cfg_log,
    input  logic                   clr_overrun,
    output logic                   overrun,
    output logic                   busy
);

    accum_state_t         state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [LOG_WIDTH-1:0] blk_log_q, blk_log_d;

    logic                 cpl;
    logic [ACC_WIDTH-1:0] cpl_acc;
    logic [LOG_WIDTH-1:0] cpl_log;
    logic [LOG_WIDTH-1:0] start_log;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] blk_len;

    // Next-state, accumulator and counter update; completion detect.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        blk_log_d = blk_log_q;
        cpl       = 1'b0;
        cpl_acc   = '0;
        cpl_log   = blk_log_q;
        start_log = clamp_log(cfg_log);
        acc_sum   = acc_q + ACC_WIDTH'(bus.in_sum);
        cnt_inc   = cnt_q + CNT_WIDTH'(1);
        blk_len   = CNT_WIDTH'(1) << blk_log_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_log_d = start_log;
                    if (start_log == '0) begin
                        // Single-sample block: complete now, accumulator stays clear.
                        cpl     = 1'b1;
                        cpl_acc = ACC_WIDTH'(bus.in_sum);
                        cpl_log = '0;
                    end else begin
                        acc_d   = ACC_WIDTH'(bus.in_sum);
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    if (cnt_inc == blk_len) begin
                        cpl     = 1'b1;
                        cpl_acc = acc_sum;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, accumulator and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            blk_log_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            blk_log_q <= blk_log_d;
        end
    end

    assign busy = (state_q == ACCUM);

    adder_tree_accum_outreg u_outreg (
        .clk           (clk),
        .rst           (rst),
        .cpl_i         (cpl),
        .cpl_acc_i     (cpl_acc),
        .cpl_log_i     (cpl_log),
        .out_ready_i   (bus.out_ready),
        .clr_overrun_i (clr_overrun),
        .out_valid_o   (bus.out_valid),
        .out_acc_o     (bus.out_acc),
        .out_mean_o    (bus.out_mean),
        .overrun_o     (overrun)
    );

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed self-checking bench for adder_tree_accum.
module tb_adder_tree_accum;
    import adder_tree_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [LOG_WIDTH-1:0] cfg_log;
    logic                 clr_overrun;
    logic                 overrun;
    logic                 busy;

    int checks;
    int errors;

    adder_tree_accum_if bus ();

    adder_tree_accum dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .cfg_log     (cfg_log),
        .clr_overrun (clr_overrun),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SUM_WIDTH-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_sum   = v;
        step();
        bus.in_valid = 1'b0;
        bus.in_sum   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", bus.out_valid); end
        checks++; if (bus.out_acc !== 24'h0) begin errors++; $display("FAIL reset_acc got %0h exp 0", bus.out_acc); end
        checks++; if (bus.out_mean !== 16'h0) begin errors++; $display("FAIL reset_mean got %0h exp 0", bus.out_mean); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0h exp 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    endtask

    task automatic test_basic();
        cfg_log = 4'd2;
        bus.out_ready = 1'b1;
        send(16'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0h exp 1", busy); end
        send(16'd2);
        send(16'd3);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0h exp 0", bus.out_valid); end
        send(16'd4);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h exp 1", bus.out_valid); end
        checks++; if (bus.out_acc !== 24'd10) begin errors++; $display("FAIL basic_acc got %0d exp 10", bus.out_acc); end
        checks++; if (bus.out_mean !== 16'd2) begin errors++; $display("FAIL basic_mean got %0d exp 2", bus.out_mean); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %0h exp 0", busy); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_max();
        cfg_log = 4'd8;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 255; i++) send(16'hFFFF);
        checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL max_255 got busy %0h valid %0h exp 1 0", busy, bus.out_valid); end
        send(16'hFFFF);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL max_valid got %0h exp 1", bus.out_valid); end
        checks++; if (bus.out_acc !== 24'hFFFF00) begin errors++; $display("FAIL max_acc got %0h exp ffff00", bus.out_acc); end
        checks++; if (bus.out_mean !== 16'hFFFF) begin errors++; $display("FAIL max_mean got %0h exp ffff", bus.out_mean); end
        step();
    endtask

    task automatic test_clamp();
        cfg_log = 4'd15;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 255; i++) send(16'd2);
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clamp_255 got valid %0h busy %0h exp 0 1", bus.out_valid, busy); end
        send(16'd2);
        checks++; if (bus.out_acc !== 24'd512 || bus.out_mean !== 16'd2) begin errors++; $display("FAIL clamp_result got acc %0d mean %0d exp 512 2", bus.out_acc, bus.out_mean); end
        step();
    endtask

    task automatic test_cfg0();
        cfg_log = 4'd0;
        bus.out_ready = 1'b1;
        send(16'd5);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd5 || bus.out_mean !== 16'd5) begin errors++; $display("FAIL cfg0_first got valid %0h acc %0d mean %0d exp 1 5 5", bus.out_valid, bus.out_acc, bus.out_mean); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg0_busy got %0h exp 0", busy); end
        send(16'd7);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd7 || bus.out_mean !== 16'd7) begin errors++; $display("FAIL cfg0_second got valid %0h acc %0d mean %0d exp 1 7 7", bus.out_valid, bus.out_acc, bus.out_mean); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cfg0_drop got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_overrun();
        cfg_log = 4'd1;
        bus.out_ready = 1'b0;
        send(16'd3);
        send(16'd3);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd6 || bus.out_mean !== 16'd3) begin errors++; $display("FAIL ovr_first got valid %0h acc %0d mean %0d exp 1 6 3", bus.out_valid, bus.out_acc, bus.out_mean); end
        send(16'd3);
        checks++; if (bus.out_acc !== 24'd6 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_hold got acc %0d ovr %0h exp 6 0", bus.out_acc, overrun); end
        send(16'd3);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0h exp 1", overrun); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd6 || bus.out_mean !== 16'd3) begin errors++; $display("FAIL ovr_keep_old got valid %0h acc %0d mean %0d exp 1 6 3", bus.out_valid, bus.out_acc, bus.out_mean); end
        step();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0h exp 1", overrun); end
        // clear and a fresh drop in the same cycle: the drop wins
        send(16'd3);
        clr_overrun = 1'b1;
        send(16'd3);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %0h exp 1", overrun); end
        step();
        clr_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0h exp 0", overrun); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_release got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_gaps();
        cfg_log = 4'd2;
        bus.out_ready = 1'b1;
        send(16'd10);
        cfg_log = 4'd0;
        step();
        send(16'd20);
        step();
        step();
        checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_hold got busy %0h valid %0h exp 1 0", busy, bus.out_valid); end
        send(16'd30);
        step();
        send(16'd40);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd100 || bus.out_mean !== 16'd25) begin errors++; $display("FAIL gap_result got valid %0h acc %0d mean %0d exp 1 100 25", bus.out_valid, bus.out_acc, bus.out_mean); end
        step();
    endtask

    task automatic test_back_to_back();
        cfg_log = 4'd1;
        bus.out_ready = 1'b1;
        send(16'd1);
        send(16'd2);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd3 || bus.out_mean !== 16'd1) begin errors++; $display("FAIL b2b_first got valid %0h acc %0d mean %0d exp 1 3 1", bus.out_valid, bus.out_acc, bus.out_mean); end
        send(16'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0h exp 1", busy); end
        send(16'd4);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd7 || bus.out_mean !== 16'd3) begin errors++; $display("FAIL b2b_second got valid %0h acc %0d mean %0d exp 1 7 3", bus.out_valid, bus.out_acc, bus.out_mean); end
        step();
    endtask

    task automatic test_rst_mid();
        cfg_log = 4'd2;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd1);
        send(16'd1);
        send(16'd1);
        checks++; if (busy !== 1'b1 || bus.out_acc !== 24'd4) begin errors++; $display("FAIL rstmid_pre got busy %0h acc %0d exp 1 4", busy, bus.out_acc); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_acc !== 24'd0 || bus.out_mean !== 16'd0 || busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_clear got valid %0h acc %0d mean %0d busy %0h ovr %0h exp all 0", bus.out_valid, bus.out_acc, bus.out_mean, busy, overrun); end
        bus.out_ready = 1'b1;
        send(16'd4);
        send(16'd8);
        send(16'd12);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got %0h exp 0", bus.out_valid); end
        send(16'd16);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd40 || bus.out_mean !== 16'd10) begin errors++; $display("FAIL rstmid_fresh got valid %0h acc %0d mean %0d exp 1 40 10", bus.out_valid, bus.out_acc, bus.out_mean); end
        step();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        cfg_log       = '0;
        clr_overrun   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_max();
        test_clamp();
        test_cfg0();
        test_overrun();
        test_gaps();
        test_back_to_back();
        test_rst_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
